// File: rtl/fp16_result_packer.sv
// Packs consecutive FP16 converter results into LANES-wide writeback words,
// carrying per-word and sticky underflow/overflow flags alongside the data.
module fp16_result_packer #(
  parameter int unsigned LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_fp16,
  input  logic                  in_unf,
  input  logic                  in_ovf,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_keep,
  output logic                  out_last,
  output logic                  out_unf,
  output logic                  out_ovf,
  output logic                  sticky_unf,
  output logic                  sticky_ovf,
  input  logic                  flag_clr
);

  localparam int unsigned DW    = 16 * LANES;
  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [LANES-1:0] keep;
    logic             last;
    logic             unf;
    logic             ovf;
  } word_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    SEALED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            asm_q, asm_d;

  logic             out_free;
  logic             accept;
  logic             drain;
  logic             completing;
  logic             load_out;
  logic [CNT_W-1:0] base_cnt;
  word_t            base;
  word_t            ins;
  word_t            load_word;

  // State, lane counter and assembly register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
    end
  end

  // Next-state: a draining sealed word frees the assembly for this cycle's element
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    load_out  = 1'b0;
    load_word = asm_q;

    out_free = !out_valid || out_ready;
    in_ready = (state_q != SEALED) || out_free;
    accept   = in_valid && in_ready;
    drain    = (state_q == SEALED) && out_free;

    base     = drain ? word_t'('0) : asm_q;
    base_cnt = drain ? '0 : cnt_q;

    ins = base;
    for (int k = 0; k < LANES; k++) begin
      if (base_cnt == CNT_W'(k)) begin
        ins.data[16*k +: 16] = in_fp16;
        ins.keep[k]          = 1'b1;
      end
    end
    ins.unf  = base.unf | in_unf;
    ins.ovf  = base.ovf | in_ovf;
    ins.last = in_last;

    completing = (base_cnt == CNT_W'(LANES - 1)) || in_last;

    if (drain) begin
      load_out  = 1'b1;
      load_word = asm_q;
      state_d   = EMPTY;
      cnt_d     = '0;
      asm_d     = '0;
    end

    if (accept) begin
      if (!completing) begin
        asm_d   = ins;
        cnt_d   = base_cnt + CNT_W'(1);
        state_d = FILLING;
      end else if (out_free && !drain) begin
        load_out  = 1'b1;
        load_word = ins;
        asm_d     = '0;
        cnt_d     = '0;
        state_d   = EMPTY;
      end else begin
        asm_d   = ins;
        cnt_d   = base_cnt;
        state_d = SEALED;
      end
    end
  end

  // Output register: holds while stalled, empties on a take with nothing new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_unf   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= load_word.data;
      out_keep  <= load_word.keep;
      out_last  <= load_word.last;
      out_unf   <= load_word.unf;
      out_ovf   <= load_word.ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky flags; a new set beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_unf <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      sticky_unf <= (sticky_unf & !flag_clr) | (accept & in_unf);
      sticky_ovf <= (sticky_ovf & !flag_clr) | (accept & in_ovf);
    end
  end

endmodule

// File: doc/fp16_result_packer.md
# fp16_result_packer

Writeback-side packer that sits directly downstream of the FP32→FP16 result converter in the MAC datapath. It accepts one converted FP16 result per cycle, along with that result's underflow/overflow flags, over a valid/ready handshake. It packs LANES consecutive results into one output word for the tile writeback bus. Per-word and sticky exception flags travel with the data.

## Interface
- LANES, default 4: FP16 elements per output word; must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  an input element is presented.
- in_ready  out  1  the packer can take the element this cycle.
- in_fp16  in  16  converted FP16 value.
- in_unf  in  1  the converter's underflow flag for this element.
- in_ovf  in  1  the converter's overflow flag for this element.
- in_last  in  1  last element of a vector; closes the current word early.
- out_valid  out  1  an output word is presented.
- out_ready  in  1  the downstream side takes the word this cycle.
- out_data  out  16*LANES  packed word; lane k is out_data[16k+15:16k].
- out_keep  out  LANES  lane-valid mask; filled lanes are contiguous from lane 0.
- out_last  out  1  this word holds an in_last element.
- out_unf  out  1  OR of in_unf over the lanes of this word.
- out_ovf  out  1  OR of in_ovf over the lanes of this word.
- sticky_unf  out  1  sticky underflow, cleared only by flag_clr.
- sticky_ovf  out  1  sticky overflow, cleared only by flag_clr.
- flag_clr  in  1  synchronous clear of both sticky flags.

## Operation
- **Storage:** an assembly register (data, keep, unf, ovf, last), a lane counter cnt (0..LANES-1), a `sealed` bit, and one output register.
- **Handshakes:** accept = in_valid & in_ready. Define out_free = !out_valid | out_ready. in_ready = !sealed | out_free (combinational; independent of in_valid and in_last).
- **Word completion:** the accepted element completes a word when cnt == LANES-1 or in_last = 1.
- **States:**
  - EMPTY (cnt=0, !sealed).
  - FILLING (cnt>0, !sealed).
  - SEALED (sealed=1; assembly holds a complete word waiting for the output register).
- **Non-completing accept:** write in_fp16 into lane cnt. Set keep[cnt]. OR in_unf/in_ovf into the assembly flags. Increment cnt.
- **Completing accept, out_free=1:** the completed word, including the current element, loads the output register directly. Assembly clears; cnt=0.
- **Completing accept, out_free=0:** the element is written into assembly and sealed=1. cnt stays at its value.
- **Sealed drain:** when sealed & out_free, the sealed word moves to the output register and sealed clears. An element accepted in the same cycle goes into lane 0 of the now-empty assembly. If that element is itself completing (in_last, or LANES==1 not allowed), it seals the new one-lane word.
- **Lane hygiene:** unfilled lanes of out_data are 16'h0000. out_keep marks the filled lanes.
- **Output register:** cleared to out_valid=0 when out_ready & out_valid and no new word loads. It holds all fields stable while out_valid & !out_ready.
- **Sticky flags:** sticky_x <= (sticky_x & !flag_clr) | (accept & in_x). A set in the same cycle as flag_clr wins.
- **Partial word with no in_last:** stays in assembly indefinitely. There is no timeout or flush port.
- **Reset:** out_valid=0, out_data=0, out_keep=0, out_last=0, out_unf=0, out_ovf=0, sticky_unf=0, sticky_ovf=0. Assembly is cleared, cnt=0, sealed=0. in_ready=1 while in reset.

## Timing
- Latency: the completing element is accepted at edge N; out_valid=1 with that word after edge N, provided out_free held at N.
- Throughput: one element per cycle sustained while out_ready=1. No bubble at word boundaries.
- Backpressure: with out_ready=0, the packer holds one word in the output register, fills assembly, and seals a second word. in_ready then drops. Up to 2*LANES elements are absorbed.
- in_ready reasserts in the same cycle out_ready rises.
- Reset mid-operation discards any partial or sealed word and any presented output. Nothing is emitted after reset until new input arrives.

## Test plan
- **Sustained stream:** LANES=4, out_ready=1, feed 8 elements 0x3C00..0x3C07, in_last on the 8th. Expect two words 0x3C03_3C02_3C01_3C00 and 0x3C07_3C06_3C05_3C04, keep=4'hF, out_last only on the second, and no in_ready drop.
- **Short vector:** in_last on the first element 0x4000. Expect out_data=0x0000_0000_0000_4000, keep=4'b0001, out_last=1 one cycle later.
- **Backpressure:** hold out_ready=0 and feed 10 elements. Expect in_ready to fall after 8 accepts. On releasing out_ready, expect words in order and the 9th/10th elements to land in lane 0/1 of the third word.
- **Flags:** set in_ovf on lane 2 of word 1 and in_unf on lane 0 of word 2. Expect out_ovf=1 only on word 1, out_unf=1 only on word 2, and sticky_ovf=sticky_unf=1. Pulse flag_clr together with a new in_ovf and expect sticky_ovf to stay 1 and sticky_unf to go 0.
- **Output stability:** out_ready toggles randomly. Check out_data/keep/last/flags are unchanged while out_valid & !out_ready, and the scoreboard sees no loss or duplication.
- **Reset mid-fill:** assert rst_n=0 with 3 lanes filled and one word presented. Expect all outputs 0 and in_ready=1. A subsequent single in_last element emits a keep=4'b0001 word.
